// File: rtl/cdr_link_ctrl_if.sv
// Bit-stream and status signals of the CDR link controller, bundled for port hookup.
// slave is the controller's view; master is the view of whatever feeds and observes it.
interface cdr_link_ctrl_if;
   logic       i_RecoveryData;
   logic       i_DataEn;
   logic       i_err;
   logic       i_ErrClr;
   logic [7:0] o_Payload;
   logic       o_PayloadValid;
   logic       o_Locked;
   logic [1:0] o_State;
   logic [7:0] o_ErrCnt;

   modport slave (
      input  i_RecoveryData, i_DataEn, i_err, i_ErrClr,
      output o_Payload, o_PayloadValid, o_Locked, o_State, o_ErrCnt
   );

   modport master (
      output i_RecoveryData, i_DataEn, i_err, i_ErrClr,
      input  o_Payload, o_PayloadValid, o_Locked, o_State, o_ErrCnt
   );
endinterface

// File: rtl/cdr_link_ctrl.sv
// Frame-sync hunter / lock tracker for a recovered bit stream (sync, payload, even parity).
// Error counting is present only when CDR_LINK_ERRCNT_EN is defined; otherwise o_ErrCnt is tied to 0.
module cdr_link_ctrl #(
   parameter logic [7:0]  SYNC_WORD  = 8'hB4,
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned UNLOCK_CNT = 2
) (
   input logic            i_clk,
   input logic            i_res,
   cdr_link_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

   state_t     state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [4:0] bitcnt_q, bitcnt_d;
   logic [3:0] good_q, good_d;
   logic [3:0] miss_q, miss_d;
   logic [7:0] payload_q, payload_d;
   logic       pvalid_q, pvalid_d;
   logic       locked_q, locked_d;

   logic [7:0] shift_in;
   logic       parity_ok;
   logic       sync_ok;
   logic       at_par;
   logic       at_sync;
   logic [4:0] bitcnt_adv;

   // shift_in is the shift register including the bit on the wire this cycle
   assign shift_in   = {shreg_q[6:0], bus.i_RecoveryData};
   assign parity_ok  = ~^{shreg_q, bus.i_RecoveryData};
   assign sync_ok    = (shift_in == SYNC_WORD);
   assign at_par     = (bitcnt_q == 5'd8);
   assign at_sync    = (bitcnt_q == 5'd16);
   assign bitcnt_adv = at_sync ? 5'd0 : bitcnt_q + 5'd1;

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      good_d    = good_q;
      miss_d    = miss_q;
      payload_d = payload_q;
      pvalid_d  = 1'b0;

      case (state_q)
         HUNT: begin
            if (bus.i_DataEn) begin
               shreg_d = shift_in;
               if (sync_ok) begin
                  state_d  = CHECK;
                  bitcnt_d = 5'd0;
                  good_d   = 4'd0;
               end
            end
         end

         CHECK: begin
            // A CDR transition error while qualifying outranks any bit processing
            if (bus.i_err) begin
               state_d  = HUNT;
               shreg_d  = 8'h00;
               bitcnt_d = 5'd0;
            end else if (bus.i_DataEn) begin
               shreg_d  = shift_in;
               bitcnt_d = bitcnt_adv;
               if (at_sync) begin
                  if (sync_ok) begin
                     good_d = good_q + 4'd1;
                     if (good_q + 4'd1 == LOCK_N) begin
                        state_d = LOCKED;
                        miss_d  = 4'd0;
                     end
                  end else begin
                     state_d = HUNT;
                     shreg_d = 8'h00;
                  end
               end
            end
         end

         LOCKED: begin
            if (bus.i_DataEn) begin
               shreg_d  = shift_in;
               bitcnt_d = bitcnt_adv;
               if (at_par && parity_ok) begin
                  payload_d = shreg_q;
                  pvalid_d  = 1'b1;
               end
               if (at_sync) begin
                  if (sync_ok) begin
                     miss_d = 4'd0;
                  end else begin
                     miss_d = miss_q + 4'd1;
                     if (miss_q + 4'd1 == UNLOCK_N) begin
                        state_d  = HUNT;
                        bitcnt_d = 5'd0;
                     end
                  end
               end
            end
         end

         default: begin
            state_d  = HUNT;
            shreg_d  = 8'h00;
            bitcnt_d = 5'd0;
         end
      endcase

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         state_q   <= HUNT;
         shreg_q   <= 8'h00;
         bitcnt_q  <= 5'd0;
         good_q    <= 4'd0;
         miss_q    <= 4'd0;
         payload_q <= 8'h00;
         pvalid_q  <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         good_q    <= good_d;
         miss_q    <= miss_d;
         payload_q <= payload_d;
         pvalid_q  <= pvalid_d;
         locked_q  <= locked_d;
      end
   end

   assign bus.o_Payload      = payload_q;
   assign bus.o_PayloadValid = pvalid_q;
   assign bus.o_Locked       = locked_q;
   assign bus.o_State        = state_q;

`ifdef CDR_LINK_ERRCNT_EN
   logic [7:0] errcnt_q, errcnt_d;
   logic       err_evt;

   // Any number of simultaneous LOCKED error sources count as one event
   always_comb begin
      err_evt = 1'b0;
      if (state_q == LOCKED) begin
         if (bus.i_err)                             err_evt = 1'b1;
         if (bus.i_DataEn && at_par  && !parity_ok) err_evt = 1'b1;
         if (bus.i_DataEn && at_sync && !sync_ok)   err_evt = 1'b1;
      end
      errcnt_d = errcnt_q;
      if (bus.i_ErrClr)
         errcnt_d = 8'h00;
      else if (err_evt && errcnt_q != 8'hFF)
         errcnt_d = errcnt_q + 8'd1;
   end

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) errcnt_q <= 8'h00;
      else       errcnt_q <= errcnt_d;
   end

   assign bus.o_ErrCnt = errcnt_q;
`else
   logic unused_errclr;
   assign unused_errclr = bus.i_ErrClr;
   assign bus.o_ErrCnt  = 8'h00;
`endif

endmodule

// File: tb/tb_cdr_link_ctrl.sv
// Self-checking bench for cdr_link_ctrl: scenario tasks plus a payload scoreboard.
// Expected error counts follow whether CDR_LINK_ERRCNT_EN is defined for the build.
module tb_cdr_link_ctrl;
   localparam logic [7:0] SYNC = 8'hB4;
`ifdef CDR_LINK_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic i_clk;
   logic i_res;
   int   tests_run;
   int   tests_failed;
   bit   gap_mode;
   logic [7:0] exp_q[$];

   cdr_link_ctrl_if bus ();

   cdr_link_ctrl dut (
      .i_clk (i_clk),
      .i_res (i_res),
      .bus   (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [7:0] exp_err(input int n);
      if (!ERR_EN) return 8'h00;
      return (n > 255) ? 8'hFF : 8'(n);
   endfunction

   // Scoreboard: every payload strobe must match the oldest pushed expectation
   always @(posedge i_clk) begin
      #1;
      if (!i_res && bus.o_PayloadValid === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_valid: got payload %h, required no strobe", bus.o_Payload);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.o_Payload !== e) begin
               tests_failed++;
               $display("FAIL payload_sb: got %h, required %h", bus.o_Payload, e);
            end
         end
      end
   end

   task automatic drive_bit(input logic b, input logic e);
      @(negedge i_clk);
      bus.i_RecoveryData = b;
      bus.i_DataEn       = 1'b1;
      bus.i_err          = e;
      @(posedge i_clk);
      #1;
      bus.i_DataEn = 1'b0;
      bus.i_err    = 1'b0;
      if (gap_mode) begin
         @(negedge i_clk);
         bus.i_RecoveryData = 1'($urandom_range(0, 1));
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) drive_bit(v[i], 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] p, input logic par, input logic [7:0] s);
      send_byte(p);
      drive_bit(par, 1'b0);
      send_byte(s);
   endtask

   task automatic do_reset();
      bus.i_RecoveryData = 1'b0;
      bus.i_DataEn       = 1'b0;
      bus.i_err          = 1'b0;
      bus.i_ErrClr       = 1'b0;
      i_res = 1'b1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_res = 1'b0;
   endtask

   task automatic lock_link();
      send_byte(SYNC);
      repeat (3) send_frame(8'h5A, 1'b0, SYNC);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
      tests_run++;
      if (got !== req) begin
         tests_failed++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic test_reset();
      do_reset();
      chk("rst_state",  {6'd0, bus.o_State}, 8'h00);
      chk("rst_locked", {7'd0, bus.o_Locked}, 8'h00);
      chk("rst_payload", bus.o_Payload, 8'h00);
      chk("rst_pvalid", {7'd0, bus.o_PayloadValid}, 8'h00);
      chk("rst_errcnt", bus.o_ErrCnt, 8'h00);
   endtask

   task automatic test_acquire();
      do_reset();
      for (int i = 7; i >= 1; i--) drive_bit(SYNC[i], 1'b0);
      chk("acq_partial_sync", {6'd0, bus.o_State}, 8'h00);
      drive_bit(SYNC[0], 1'b0);
      chk("acq_first_sync", {6'd0, bus.o_State}, 8'h01);
      send_frame(8'h5A, 1'b0, SYNC);
      chk("acq_good1", {6'd0, bus.o_State}, 8'h01);
      send_frame(8'h5A, 1'b0, SYNC);
      chk("acq_good2", {6'd0, bus.o_State}, 8'h01);
      send_frame(8'h5A, 1'b0, SYNC);
      chk("acq_locked_state", {6'd0, bus.o_State}, 8'h02);
      chk("acq_locked_flag", {7'd0, bus.o_Locked}, 8'h01);
      chk("acq_no_payload", bus.o_Payload, 8'h00);
   endtask

   task automatic test_payload();
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      drive_bit(1'b0, 1'b0);
      chk("pay_valid", {7'd0, bus.o_PayloadValid}, 8'h01);
      chk("pay_value", bus.o_Payload, 8'h3C);
      drive_bit(SYNC[7], 1'b0);
      chk("pay_valid_1cyc", {7'd0, bus.o_PayloadValid}, 8'h00);
      for (int i = 6; i >= 0; i--) drive_bit(SYNC[i], 1'b0);
      // Idle cycles between strobes must not disturb framing
      gap_mode = 1'b1;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, SYNC);
      gap_mode = 1'b0;
      chk("pay_gap_state", {6'd0, bus.o_State}, 8'h02);
      chk("pay_gap_value", bus.o_Payload, 8'hA5);
   endtask

   task automatic test_sync_miss();
      do_reset();
      lock_link();
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 8'h00);
      chk("miss1_state", {6'd0, bus.o_State}, 8'h02);
      chk("miss1_errcnt", bus.o_ErrCnt, exp_err(1));
      exp_q.push_back(8'h66);
      send_frame(8'h66, 1'b0, SYNC);
      chk("miss_recover", {6'd0, bus.o_State}, 8'h02);
      chk("miss_recover_err", bus.o_ErrCnt, exp_err(1));
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 8'h00);
      chk("miss2a_state", {6'd0, bus.o_State}, 8'h02);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 8'h00);
      chk("unlock_state", {6'd0, bus.o_State}, 8'h00);
      chk("unlock_flag", {7'd0, bus.o_Locked}, 8'h00);
      chk("unlock_errcnt", bus.o_ErrCnt, exp_err(3));
   endtask

   task automatic test_parity_err();
      do_reset();
      lock_link();
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b0, SYNC);
      send_byte(8'h01);
      drive_bit(1'b0, 1'b0);
      chk("par_no_valid", {7'd0, bus.o_PayloadValid}, 8'h00);
      send_byte(SYNC);
      chk("par_payload_held", bus.o_Payload, 8'h3C);
      chk("par_errcnt1", bus.o_ErrCnt, exp_err(1));
      for (int n = 2; n <= 300; n++) send_frame(8'h01, 1'b0, SYNC);
      chk("par_errcnt_sat", bus.o_ErrCnt, exp_err(300));
      chk("par_state", {6'd0, bus.o_State}, 8'h02);
      send_byte(8'h01);
      bus.i_ErrClr = 1'b1;
      drive_bit(1'b0, 1'b0);
      bus.i_ErrClr = 1'b0;
      chk("par_clr_prio", bus.o_ErrCnt, 8'h00);
      send_byte(SYNC);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b0, SYNC);
      chk("par_good_after", bus.o_Payload, 8'h81);
   endtask

   task automatic test_err_check();
      do_reset();
      send_byte(SYNC);
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b1);
      chk("err_check_hunt", {6'd0, bus.o_State}, 8'h00);
      send_byte(SYNC);
      chk("err_rehunt", {6'd0, bus.o_State}, 8'h01);
      repeat (3) send_frame(8'h5A, 1'b0, SYNC);
      chk("err_relock", {6'd0, bus.o_State}, 8'h02);
      @(negedge i_clk);
      bus.i_err = 1'b1;
      @(posedge i_clk);
      #1;
      bus.i_err = 1'b0;
      chk("err_locked_stay", {6'd0, bus.o_State}, 8'h02);
      chk("err_locked_cnt", bus.o_ErrCnt, exp_err(1));
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, SYNC);
      chk("err_locked_payload", bus.o_Payload, 8'h5A);
   endtask

   task automatic test_reset_mid();
      for (int i = 7; i >= 4; i--) drive_bit(8'h3C >> i, 1'b0);
      @(negedge i_clk);
      i_res = 1'b1;
      #1;
      chk("mid_rst_state", {6'd0, bus.o_State}, 8'h00);
      chk("mid_rst_locked", {7'd0, bus.o_Locked}, 8'h00);
      chk("mid_rst_payload", bus.o_Payload, 8'h00);
      chk("mid_rst_errcnt", bus.o_ErrCnt, 8'h00);
      @(negedge i_clk);
      i_res = 1'b0;
      send_byte(SYNC);
      chk("mid_first_sync", {6'd0, bus.o_State}, 8'h01);
      repeat (2) send_frame(8'h5A, 1'b0, SYNC);
      chk("mid_not_yet", {6'd0, bus.o_State}, 8'h01);
      send_frame(8'h5A, 1'b0, SYNC);
      chk("mid_relocked", {6'd0, bus.o_State}, 8'h02);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      gap_mode     = 1'b0;
      i_res        = 1'b1;
      test_reset();
      test_acquire();
      test_payload();
      test_sync_miss();
      test_parity_err();
      test_err_check();
      test_reset_mid();
      repeat (3) @(posedge i_clk);
      #2;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_drain: got %0d pending payloads, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cdr_link_ctrl.md
CDR_LINK_CTRL -- requirements
Module: cdr_link_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hB4, the frame sync pattern, MSB received first.
REQ-002 SHALL have parameter LOCK_CNT, default 3, the consecutive good syncs needed for lock (range 1..15).
REQ-003 SHALL have parameter UNLOCK_CNT, default 2, the consecutive bad syncs that drop lock (range 1..15).
REQ-004 i_clk  input  1  the single clock, rising edge.
REQ-005 i_res  input  1  asynchronous, active-high reset.
REQ-006 i_RecoveryData  input  1  recovered bit from the CDR.
REQ-007 i_DataEn  input  1  one-cycle strobe, i_RecoveryData valid.
REQ-008 i_err  input  1  CDR transition-error pulse.
REQ-009 i_ErrClr  input  1  synchronous clear of o_ErrCnt.
REQ-010 o_Payload  output  8  last accepted payload byte.
REQ-011 o_PayloadValid  output  1  one-cycle strobe, o_Payload updated.
REQ-012 o_Locked  output  1  high in LOCKED state.
REQ-013 o_State  output  2  state code: HUNT=0, CHECK=1, LOCKED=2.
REQ-014 o_ErrCnt  output  8  saturating error count.

Function
REQ-015 Frame SHALL be 17 bits, MSB first: 8-bit sync, 8-bit payload, 1 even-parity bit over the payload.
REQ-016 All bit processing SHALL occur only in cycles with i_DataEn=1; other cycles hold the shift register, bit counter and state.
REQ-017 HUNT: every enabled bit SHALL shift into an 8-bit register; when the register including the current bit equals SYNC_WORD, go to CHECK on the next edge, clearing the bit counter and the good counter.
REQ-018 In CHECK and LOCKED, bit counter values 0..7 SHALL be payload, 8 parity, and 9..16 expected sync; the counter wraps 16->0.
REQ-019 At counter 16, the sync SHALL be compared, using the 8 bits just received.
REQ-020 CHECK, sync match: increment the good counter; on reaching LOCK_CNT go to LOCKED and clear the miss counter.
REQ-021 CHECK, sync mismatch: go to HUNT with the shift register cleared.
REQ-022 LOCKED, sync match: clear the miss counter.
REQ-023 LOCKED, sync mismatch: increment the miss counter; on reaching UNLOCK_CNT go to HUNT, otherwise stay LOCKED.
REQ-024 LOCKED, counter 8 with correct parity: o_Payload SHALL load on the next edge and o_PayloadValid SHALL pulse exactly one cycle (1-cycle latency from the parity i_DataEn).
REQ-025 Parity error in LOCKED SHALL suppress o_PayloadValid, leave o_Payload unchanged, and count as an error event.
REQ-026 Payload SHALL never be emitted in HUNT or CHECK.
REQ-027 i_err in CHECK SHALL force HUNT on the next edge.
REQ-028 i_err in LOCKED SHALL count as an error event only; it SHALL NOT change state.
REQ-029 i_err coincident with i_DataEn SHALL still process the bit, except where REQ-027 forces HUNT, which takes priority.
REQ-030 Error events (parity error, LOCKED sync mismatch, LOCKED i_err) SHALL add 1 each to o_ErrCnt, saturating at 8'hFF; multiple events in one cycle add 1 total.
REQ-031 i_ErrClr SHALL set o_ErrCnt to 0 and take priority over a simultaneous increment.
REQ-032 o_Locked SHALL be registered and equal (o_State==2).

Reset
REQ-033 i_res=1 SHALL asynchronously force HUNT; clear the shift register and all counters; set o_Payload=0, o_PayloadValid=0, o_Locked=0, o_State=0, o_ErrCnt=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release, hunting restarts from an empty shift register.

Configuration
REQ-035 Macro CDR_LINK_ERRCNT_EN SHALL gate error counting.
REQ-036 With CDR_LINK_ERRCNT_EN defined, REQ-030/031 apply.
REQ-037 Without CDR_LINK_ERRCNT_EN, o_ErrCnt SHALL be constant 0, i_ErrClr ignored, no counter logic synthesized, and all other behaviour unchanged.

Verification
REQ-038 Three clean frames, payload 8'h5A with parity 0, after reset -> o_State 0->1 at first sync, 2 at third sync end; no o_PayloadValid before LOCKED.
REQ-039 Locked link, frame payload 8'h3C, parity 0 -> o_PayloadValid one cycle after the parity strobe, o_Payload=8'h3C.
REQ-040 Locked, one frame with sync 8'h00 then a good frame -> stays LOCKED, o_ErrCnt=1; two consecutive bad syncs -> HUNT, o_Locked=0.
REQ-041 Locked, payload 8'h01 with parity 0 -> no o_PayloadValid, o_ErrCnt+1; 300 such errors -> o_ErrCnt=8'hFF; i_ErrClr coincident with an error -> 0.
REQ-042 i_err pulse in CHECK -> HUNT next cycle; i_res pulse mid-payload in LOCKED -> all outputs 0 immediately, relock needs 3 fresh syncs.
REQ-043 Build without CDR_LINK_ERRCNT_EN, rerun REQ-041 stimulus -> o_ErrCnt stays 0, payload behaviour identical.
